// File: rtl/tdc_interval_gen_if.sv
// Bus between the interval generator and its TDC / code source.
// The generator owns the master modport; the code source and TDC side use slave.
interface tdc_interval_gen_if #(
    parameter int unsigned WIDTH = 6
);
    logic [WIDTH-1:0] code_in;
    logic             code_valid;
    logic             code_ready;
    logic             start;
    logic             stop;
    logic             tdc_reset;
    logic [WIDTH-1:0] tdc_code;
    logic [WIDTH-1:0] meas_code;
    logic             meas_valid;
    logic             meas_err;
    logic [7:0]       err_count;
    logic             busy;

    modport master (
        input  code_in, code_valid, tdc_code,
        output code_ready, start, stop, tdc_reset,
               meas_code, meas_valid, meas_err, err_count, busy
    );

    modport slave (
        output code_in, code_valid, tdc_code,
        input  code_ready, start, stop, tdc_reset,
               meas_code, meas_valid, meas_err, err_count, busy
    );
endinterface

// File: rtl/tdc_interval_gen.sv
// Start/stop interval generator for a Vernier TDC: clears the TDC, emits start, then stop
// code*SCALE cycles later, samples the TDC result after a settle window and flags mismatches.
module tdc_interval_gen #(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned SCALE  = 1,
    parameter int unsigned CLR_W  = 2,
    parameter int unsigned SETTLE = 4,
    parameter int unsigned GAP_W  = 2
) (
    input  logic               clk,
    input  logic               reset,
    tdc_interval_gen_if.master bus
);
    localparam int unsigned CW   = WIDTH + $clog2(SCALE) + 1;
    localparam int unsigned PMAX = (CLR_W > SETTLE) ? ((CLR_W > GAP_W) ? CLR_W : GAP_W)
                                                    : ((SETTLE > GAP_W) ? SETTLE : GAP_W);
    localparam int unsigned PW   = $clog2(PMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_RUN, S_SETTLE, S_CAPTURE, S_GAP
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_code;
    logic [CW-1:0]    r_icnt;
    logic [PW-1:0]    r_pcnt;
    logic             r_ready;
    logic             r_start;
    logic             r_stop;
    logic [WIDTH-1:0] r_meas_code;
    logic             r_meas_valid;
    logic             r_meas_err;
    logic [7:0]       r_err_count;
    logic             r_busy;
    logic [CW-1:0]    w_target;
    logic             w_mismatch;

    // Full-width product so the largest code never wraps the interval counter.
    assign w_target   = CW'(r_code) * CW'(SCALE);
    assign w_mismatch = (bus.tdc_code != r_code);

    // Shot sequencer; r_pcnt times the fixed phases, r_icnt times the coded interval.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_code       <= '0;
            r_icnt       <= '0;
            r_pcnt       <= '0;
            r_ready      <= 1'b0;
            r_start      <= 1'b0;
            r_stop       <= 1'b0;
            r_meas_code  <= '0;
            r_meas_valid <= 1'b0;
            r_meas_err   <= 1'b0;
            r_err_count  <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_meas_valid <= 1'b0;
            r_meas_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.code_valid && r_ready) begin
                        r_code  <= bus.code_in;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_pcnt  <= PW'(1);
                        r_state <= S_CLEAR;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (r_pcnt == PW'(CLR_W)) begin
                        r_start <= 1'b1;
                        r_icnt  <= CW'(1);
                        r_pcnt  <= PW'(1);
                        // A zero interval raises stop on the same edge as start.
                        if (w_target == '0) begin
                            r_stop  <= 1'b1;
                            r_state <= S_SETTLE;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end else begin
                        r_pcnt <= r_pcnt + PW'(1);
                    end
                end
                S_RUN: begin
                    if (r_icnt == w_target) begin
                        r_stop  <= 1'b1;
                        r_state <= S_SETTLE;
                    end else begin
                        r_icnt <= r_icnt + CW'(1);
                    end
                end
                S_SETTLE: begin
                    if (r_pcnt == PW'(SETTLE)) begin
                        r_start      <= 1'b0;
                        r_stop       <= 1'b0;
                        r_meas_code  <= bus.tdc_code;
                        r_meas_valid <= 1'b1;
                        r_meas_err   <= w_mismatch;
                        if (w_mismatch && (r_err_count != 8'hFF)) begin
                            r_err_count <= r_err_count + 8'd1;
                        end
                        r_pcnt  <= PW'(1);
                        r_state <= S_CAPTURE;
                    end else begin
                        r_pcnt <= r_pcnt + PW'(1);
                    end
                end
                S_CAPTURE, S_GAP: begin
                    // The capture cycle is the first cycle of the low gap.
                    if (r_pcnt == PW'(GAP_W)) begin
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_pcnt  <= r_pcnt + PW'(1);
                        r_state <= S_GAP;
                    end
                end
                default: begin
                    r_start <= 1'b0;
                    r_stop  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.code_ready = r_ready;
    assign bus.start      = r_start;
    assign bus.stop       = r_stop;
    assign bus.tdc_reset  = reset | (r_state == S_CLEAR);
    assign bus.meas_code  = r_meas_code;
    assign bus.meas_valid = r_meas_valid;
    assign bus.meas_err   = r_meas_err;
    assign bus.err_count  = r_err_count;
    assign bus.busy       = r_busy;
endmodule

// File: tb/tb_tdc_interval_gen.sv
// Bench for tdc_interval_gen: a behavioural TDC measures the start/stop spacing, a scoreboard
// checks every reported measurement, and a vector table checks edge latencies.
module tb_tdc_interval_gen;
    logic clk;
    logic reset;

    tdc_interval_gen_if #(.WIDTH(6)) if0 ();
    tdc_interval_gen_if #(.WIDTH(6)) if1 ();

    tdc_interval_gen #(.WIDTH(6)) u_dut0 (.clk(clk), .reset(reset), .bus(if0));
    tdc_interval_gen #(.WIDTH(6), .SCALE(3)) u_dut1 (.clk(clk), .reset(reset), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] code;
        logic       err;
    } sb_t;

    typedef struct {
        logic [5:0] code;
        int         d_start;
        int         d_stop;
        int         d_mv;
        int         d_rdy;
    } vec_t;

    sb_t  sb0[$];
    sb_t  sb1[$];
    vec_t tbl[5];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc_e[2], st_e[2], sp_e[2], mv_e[2], rdy_e[2], trst_e[2], mv_cnt[2];
    logic prev_st[2], prev_sp[2], prev_rdy[2], prev_trst[2];
    logic force_en[2];
    logic [5:0] force_val;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic rdy(input int i);
        return (i == 0) ? if0.code_ready : if1.code_ready;
    endfunction

    task automatic set_in(input int i, input logic v, input logic [5:0] c);
        if (i == 0) begin
            if0.code_valid = v;
            if0.code_in    = c;
        end else begin
            if1.code_valid = v;
            if1.code_in    = c;
        end
    endtask

    // Behavioural TDC plus scoreboard consumer for one generator instance.
    task automatic mon(input int i, input logic st, input logic sp, input logic rd,
                       input logic trst, input logic mv, input logic [5:0] mc, input logic me);
        int  d;
        sb_t e;
        if (!reset) begin
            if (trst && !prev_trst[i]) trst_e[i] = cyc;
            if (st && !prev_st[i]) begin
                st_e[i] = cyc;
                chk("tdc_reset_lead", st_e[i] - trst_e[i], 2);
            end
            if (sp && !prev_sp[i]) begin
                sp_e[i] = cyc;
                chk("stop_after_start", int'(st), 1);
                d = (cyc - st_e[i]) / ((i == 0) ? 1 : 3);
                if (!force_en[i]) begin
                    if (i == 0) if0.tdc_code = (d > 63) ? 6'd63 : 6'(d);
                    else        if1.tdc_code = (d > 63) ? 6'd63 : 6'(d);
                end
            end
            if (prev_st[i] && !st) chk("fall_together_at_capture", int'({sp, mv}), 1);
            if (rd && !prev_rdy[i]) rdy_e[i] = cyc;
            if (mv) begin
                mv_e[i] = cyc;
                mv_cnt[i]++;
                if ((i == 0) ? (sb0.size() == 0) : (sb1.size() == 0)) begin
                    chk("unexpected_meas_valid", 1, 0);
                end else begin
                    e = (i == 0) ? sb0.pop_front() : sb1.pop_front();
                    chk("meas_code", int'(mc), int'(e.code));
                    chk("meas_err", int'(me), int'(e.err));
                end
            end
        end
        prev_st[i]   = st;
        prev_sp[i]   = sp;
        prev_rdy[i]  = rd;
        prev_trst[i] = trst;
    endtask

    // One clock: note handshakes that will complete, advance, then observe #1 after the edge.
    task automatic tick();
        logic a0, a1;
        logic [5:0] c0, c1;
        sb_t e;
        a0 = if0.code_valid && if0.code_ready && !reset;
        a1 = if1.code_valid && if1.code_ready && !reset;
        c0 = if0.code_in;
        c1 = if1.code_in;
        @(posedge clk);
        cyc++;
        #1;
        if (a0) begin
            acc_e[0] = cyc;
            e.code = force_en[0] ? force_val : c0;
            e.err  = force_en[0] && (force_val != c0);
            sb0.push_back(e);
            chk("busy_ready_after_accept0", int'({if0.busy, if0.code_ready}), 2);
        end
        if (a1) begin
            acc_e[1] = cyc;
            e.code = c1;
            e.err  = 1'b0;
            sb1.push_back(e);
            chk("busy_ready_after_accept1", int'({if1.busy, if1.code_ready}), 2);
        end
        mon(0, if0.start, if0.stop, if0.code_ready, if0.tdc_reset, if0.meas_valid,
            if0.meas_code, if0.meas_err);
        mon(1, if1.start, if1.stop, if1.code_ready, if1.tdc_reset, if1.meas_valid,
            if1.meas_code, if1.meas_err);
    endtask

    task automatic run_shot(input int i, input logic [5:0] code);
        int n;
        int old;
        n = 0;
        while (rdy(i) !== 1'b1 && n < 500) begin tick(); n++; end
        if (n >= 500) chk("ready_timeout", 0, 1);
        set_in(i, 1'b1, code);
        old = acc_e[i];
        n = 0;
        while (acc_e[i] == old && n < 5) begin tick(); n++; end
        set_in(i, 1'b0, code);
        if (acc_e[i] == old) begin
            chk("accept_timeout", 0, 1);
            return;
        end
        n = 0;
        while (rdy_e[i] <= acc_e[i] && n < 500) begin tick(); n++; end
        if (rdy_e[i] <= acc_e[i]) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int n, m, prev_acc, mv_base;

        // code, start, stop, meas_valid, code_ready offsets from the accept edge (defaults)
        tbl[0] = '{code: 6'd5,  d_start: 2, d_stop: 7,  d_mv: 11, d_rdy: 13};
        tbl[1] = '{code: 6'd0,  d_start: 2, d_stop: 2,  d_mv: 6,  d_rdy: 8};
        tbl[2] = '{code: 6'd1,  d_start: 2, d_stop: 3,  d_mv: 7,  d_rdy: 9};
        tbl[3] = '{code: 6'd63, d_start: 2, d_stop: 65, d_mv: 69, d_rdy: 71};
        tbl[4] = '{code: 6'd33, d_start: 2, d_stop: 35, d_mv: 39, d_rdy: 41};

        for (int i = 0; i < 2; i++) begin
            acc_e[i] = -1; st_e[i] = -1; sp_e[i] = -1; mv_e[i] = -1;
            rdy_e[i] = -1; trst_e[i] = -1; mv_cnt[i] = 0;
            prev_st[i] = 1'b0; prev_sp[i] = 1'b0; prev_rdy[i] = 1'b0; prev_trst[i] = 1'b0;
            force_en[i] = 1'b0;
        end
        force_val = 6'd0;
        reset = 1'b1;
        set_in(0, 1'b0, 6'd0);
        set_in(1, 1'b0, 6'd0);
        if0.tdc_code = 6'd0;
        if1.tdc_code = 6'd0;

        // Reset values
        tick(); tick();
        chk("rst_code_ready", int'(if0.code_ready), 0);
        chk("rst_start_stop", int'({if0.start, if0.stop}), 0);
        chk("rst_tdc_reset", int'(if0.tdc_reset), 1);
        chk("rst_meas", int'({if0.meas_valid, if0.meas_err, if0.busy}), 0);
        chk("rst_meas_code", int'(if0.meas_code), 0);
        chk("rst_err_count", int'(if0.err_count), 0);
        reset = 1'b0;
        tick();
        chk("ready_after_release", int'(if0.code_ready), 1);
        chk("tdc_reset_idle", int'(if0.tdc_reset), 0);

        // T1: reset mid-RUN with code 40
        set_in(0, 1'b1, 6'd40);
        tick();
        set_in(0, 1'b0, 6'd40);
        chk("t1_accept", acc_e[0], cyc);
        for (int k = 0; k < 6; k++) tick();
        chk("t1_in_run", int'({if0.start, if0.stop}), 2);
        mv_base = mv_cnt[0];
        #2 reset = 1'b1;
        #1;
        chk("t1_async_start_stop", int'({if0.start, if0.stop}), 0);
        chk("t1_async_tdc_reset", int'(if0.tdc_reset), 1);
        chk("t1_async_busy_ready", int'({if0.busy, if0.code_ready}), 0);
        sb0.delete();
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("t1_ready_after_release", int'(if0.code_ready), 1);
        for (int k = 0; k < 50; k++) tick();
        chk("t1_no_meas_valid", mv_cnt[0] - mv_base, 0);

        // T2/T3: latency table on the default instance
        for (int j = 0; j < 5; j++) begin
            run_shot(0, tbl[j].code);
            chk("lat_start", st_e[0] - acc_e[0], tbl[j].d_start);
            chk("lat_stop", sp_e[0] - acc_e[0], tbl[j].d_stop);
            chk("lat_meas_valid", mv_e[0] - acc_e[0], tbl[j].d_mv);
            chk("lat_code_ready", rdy_e[0] - acc_e[0], tbl[j].d_rdy);
        end
        chk("meas_code_hold", int'(if0.meas_code), 33);

        // T4: SCALE=3, largest code
        run_shot(1, 6'd63);
        chk("t4_interval_189", sp_e[1] - st_e[1], 189);
        chk("t4_mv_latency", mv_e[1] - acc_e[1], 195);
        run_shot(1, 6'd1);
        chk("t4_interval_3", sp_e[1] - st_e[1], 3);

        // T5: forced wrong TDC result, then saturation
        chk("t5_err_count_before", int'(if0.err_count), 0);
        force_en[0] = 1'b1;
        force_val   = 6'd7;
        if0.tdc_code = 6'd7;
        run_shot(0, 6'd6);
        chk("t5_err_count_one", int'(if0.err_count), 1);
        for (int k = 0; k < 299; k++) run_shot(0, 6'd6);
        chk("t5_err_count_sat", int'(if0.err_count), 255);
        run_shot(0, 6'd7);
        chk("t5_match_no_inc", int'(if0.err_count), 255);
        force_en[0] = 1'b0;

        // T6: code_valid held high, back-to-back shots
        mv_base  = mv_cnt[0];
        prev_acc = acc_e[0];
        set_in(0, 1'b1, 6'd3);
        for (int s = 0; s < 5; s++) begin
            m = acc_e[0];
            n = 0;
            while (acc_e[0] == m && n < 40) begin tick(); n++; end
            if (acc_e[0] == m) chk("t6_accept_timeout", 0, 1);
            else if (s > 0) chk("t6_accept_spacing", acc_e[0] - prev_acc, 12);
            prev_acc = acc_e[0];
        end
        set_in(0, 1'b0, 6'd3);
        n = 0;
        while (rdy_e[0] <= acc_e[0] && n < 100) begin tick(); n++; end
        chk("t6_one_result_per_accept", mv_cnt[0] - mv_base, 5);

        chk("sb0_drained", sb0.size(), 0);
        chk("sb1_drained", sb1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
